// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the bit-serial arithmetic blocks of the arithmetic
// library.
//   arith_state_e : sequencing states used by the serial operators
//   ARITH_WIDTH   : default operand width for library blocks
// -----------------------------------------------------------------------------
package arith_pkg;

    // Default operand/result width for the arithmetic library blocks.
    localparam int ARITH_WIDTH = 8;

    // Sequencing states of a bit-serial operator.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } arith_state_e;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational full-subtractor cell, the mirror of the library's
// full-adder cell. It computes a - b - bin for single bits.
// Ports:
//   a    in  : minuend bit
//   b    in  : subtrahend bit
//   bin  in  : borrow in
//   d    out : difference bit
//   bout out : borrow out (set when a < b + bin)
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial, LSB-first subtractor computing diff = a - b - bin (mod 2^WIDTH)
// with a single full-subtractor cell and a borrow flip-flop. This block trades
// latency for area: one operation takes WIDTH+2 cycles.
//
// Handshake: a start seen in IDLE latches a, b and bin. busy is high for the
// WIDTH shift cycles, and done pulses for one cycle once the results are
// valid. Results hold until the next accepted operation completes.
//
// Ports:
//   clk    in  : system clock, rising-edge active
//   rst_n  in  : asynchronous active-low reset
//   start  in  : operation request, only sampled in IDLE
//   a      in  : minuend   [WIDTH-1:0]
//   b      in  : subtrahend [WIDTH-1:0]
//   bin    in  : borrow in
//   busy   out : operation in progress
//   done   out : one-cycle pulse, results valid from this cycle on
//   diff   out : difference [WIDTH-1:0]
//   bout   out : borrow out (unsigned underflow)
//   ovf    out : two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // The counter must be able to hold WIDTH itself so it never wraps within
    // an operation.
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    arith_state_e     state_r;
    arith_state_e     state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] d_sh_r;
    logic [WIDTH-1:0] d_sh_next_s;
    logic             br_r;
    logic             cell_d_s;
    logic             cell_bout_s;
    logic             last_bit_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;

    // The single arithmetic cell: operand LSBs plus the running borrow.
    full_subtractor u_cell (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (br_r),
        .d    (cell_d_s),
        .bout (cell_bout_s)
    );

    // The counter still holds the index of the bit being processed, so the
    // final bit is the one at index WIDTH-1.
    assign last_bit_s = (cnt_r == CNT_LAST);

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Difference register after this cycle's shift: the new bit enters at the
    // MSB end, so after WIDTH shifts bit 0 of a sits in bit 0 of the result.
    always_comb begin
        d_sh_next_s              = d_sh_r >> 1;
        d_sh_next_s[WIDTH-1]     = cell_d_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, serial shifting and result loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r <= '0;
            b_sh_r <= '0;
            d_sh_r <= '0;
            br_r   <= 1'b0;
            cnt_r  <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        br_r   <= bin;
                        d_sh_r <= '0;
                        cnt_r  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_r <= a_sh_r >> 1;
                    b_sh_r <= b_sh_r >> 1;
                    br_r   <= cell_bout_s;
                    d_sh_r <= d_sh_next_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (last_bit_s) begin
                        // br_r is the borrow into the MSB, cell_bout_s the
                        // borrow out of it; they differ exactly on signed
                        // overflow.
                        diff_r <= d_sh_next_s;
                        bout_r <= cell_bout_s;
                        ovf_r  <= br_r ^ cell_bout_s;
                    end
                end
                DONE: begin
                    // Results are already loaded; nothing moves.
                end
                default: begin
                    // Unreachable encoding; the FSM returns to IDLE.
                end
            endcase
        end
    end

    // Registered handshake flags, derived from the state being entered so
    // they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == SHIFT);
            done_r <= (state_next_s == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;
    assign ovf  = ovf_r;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor, with an 8-bit and a 1-bit
// instance. An arithmetic reference model predicts the outputs every cycle,
// and hand-computed literals pin the model on the directed vectors.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W8 = 8;
    localparam int W1 = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8     = 8'd0;
    logic [7:0] b8     = 8'd0;
    logic       bin8   = 1'b0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    logic       start1 = 1'b0;
    logic [0:0] a1     = 1'b0;
    logic [0:0] b1     = 1'b0;
    logic       bin1   = 1'b0;
    logic       busy1, done1, bout1, ovf1;
    logic [0:0] diff1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(W1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {ovf, bout, diff[7:0]}.
    function automatic logic [9:0] ref_sub(input int w, input longint a, input longint b,
                                           input longint bi);
        longint m, d, sa, sb, sd;
        logic   o, bo;
        m  = longint'(1) << w;
        d  = a - b - bi;
        if (d < 0) d = d + m;
        bo = (a < b + bi);
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sd = sa - sb - bi;
        o  = (sd < -(m / 2)) || (sd > (m / 2) - 1);
        return {o, bo, d[7:0]};
    endfunction

    // Model timeline: ph = cycles since the accepting edge (0 = idle).
    int         ph8  = 0;
    int         ph1  = 0;
    logic [9:0] pend8 = '0, exp8 = '0;
    logic [9:0] pend1 = '0, exp1 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph8  = 0;
            exp8 = '0;
        end else if (ph8 == 0) begin
            if (start8 === 1'b1) begin
                ph8   = 1;
                pend8 = ref_sub(W8, longint'(a8), longint'(b8), longint'(bin8));
            end
        end else if (ph8 == W8 + 1) begin
            ph8 = 0;
        end else begin
            ph8++;
            if (ph8 == W8 + 1) exp8 = pend8;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph1  = 0;
            exp1 = '0;
        end else if (ph1 == 0) begin
            if (start1 === 1'b1) begin
                ph1   = 1;
                pend1 = ref_sub(W1, longint'(a1), longint'(b1), longint'(bin1));
            end
        end else if (ph1 == W1 + 1) begin
            ph1 = 0;
        end else begin
            ph1++;
            if (ph1 == W1 + 1) exp1 = pend1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("busy8", busy8, (ph8 >= 1 && ph8 <= W8));
            chk("done8", done8, (ph8 == W8 + 1));
            chk("diff8", diff8, exp8[7:0]);
            chk("bout8", bout8, exp8[8]);
            chk("ovf8",  ovf8,  exp8[9]);
            chk("busy1", busy1, (ph1 >= 1 && ph1 <= W1));
            chk("done1", done1, (ph1 == W1 + 1));
            chk("diff1", diff1, exp1[0]);
            chk("bout1", bout1, exp1[8]);
            chk("ovf1",  ovf1,  exp1[9]);
        end
    end

    // Pulse start for one accepting edge, then wait for done.
    // lat = number of cycles from the accepting edge to the done cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int lat);
        @(posedge clk); #2;
        a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done8 === 1'b1) break;
        end
        if (done8 !== 1'b1) chk("done8_timeout", done8, 1'b1);
    endtask

    task automatic run1(input logic a, input logic b, input logic bi, output int lat);
        @(posedge clk); #2;
        a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done1 === 1'b1) break;
        end
        if (done1 !== 1'b1) chk("done1_timeout", done1, 1'b1);
    endtask

    task automatic wait_done8();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) break;
        end
        if (done8 !== 1'b1) chk("done8_timeout", done8, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [7:0] dtab;
        logic [7:0] btab;
        logic [2:0] idx;
        dtab = 8'b1001_0110;
        btab = 8'b1000_1110;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_done8", done8, 1'b0);
        chk("rst_diff8", diff8, 8'd0);
        chk("rst_bout8", bout8, 1'b0);
        chk("rst_ovf8",  ovf8,  1'b0);
        chk("rst_busy1", busy1, 1'b0);
        rst_n = 1'b1;

        // 1: basic subtraction and latency
        run8(8'd100, 8'd58, 1'b0, lat);
        chk("t1_latency", lat, 9);
        chk("t1_diff", diff8, 8'd42);
        chk("t1_bout", bout8, 1'b0);
        chk("t1_ovf",  ovf8,  1'b0);

        // 2: unsigned underflow, borrow-in only
        run8(8'd5, 8'd10, 1'b0, lat);
        chk("t2a_diff", diff8, 8'hFB);
        chk("t2a_bout", bout8, 1'b1);
        chk("t2a_ovf",  ovf8,  1'b0);
        run8(8'd0, 8'd0, 1'b1, lat);
        chk("t2b_diff", diff8, 8'hFF);
        chk("t2b_bout", bout8, 1'b1);
        chk("t2b_ovf",  ovf8,  1'b0);

        // 3: signed overflow both directions
        run8(8'h80, 8'h01, 1'b0, lat);
        chk("t3a_diff", diff8, 8'h7F);
        chk("t3a_bout", bout8, 1'b0);
        chk("t3a_ovf",  ovf8,  1'b1);
        run8(8'h7F, 8'hFF, 1'b0, lat);
        chk("t3b_diff", diff8, 8'h80);
        chk("t3b_bout", bout8, 1'b1);
        chk("t3b_ovf",  ovf8,  1'b1);

        // 5: asynchronous reset mid-operation
        @(posedge clk); #2;
        a8 = 8'd200; b8 = 8'd100; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("t5_busy_before", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy8, 1'b0);
        chk("t5_done", done8, 1'b0);
        chk("t5_diff", diff8, 8'd0);
        chk("t5_bout", bout8, 1'b0);
        chk("t5_ovf",  ovf8,  1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t5_no_done", done8, 1'b0);
        end
        run8(8'd200, 8'd100, 1'b0, lat);
        chk("t5_fresh_diff", diff8, 8'd100);
        chk("t5_fresh_bout", bout8, 1'b0);
        chk("t5_fresh_ovf",  ovf8,  1'b1);

        // 4: start held high, operands changed mid-operation
        @(posedge clk); #2;
        a8 = 8'd20; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #2;
        repeat (3) @(posedge clk);
        #2;
        a8 = 8'd50; b8 = 8'd8;
        wait_done8();
        chk("t4_first", diff8, 8'd17);
        @(negedge clk);
        chk("t4_gap_busy", busy8, 1'b0);
        chk("t4_gap_done", done8, 1'b0);
        @(negedge clk);
        chk("t4_reaccept_busy", busy8, 1'b1);
        start8 = 1'b0;
        wait_done8();
        chk("t4_second", diff8, 8'd42);

        // 6: WIDTH=1 truth table
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            run1(idx[2], idx[1], idx[0], lat);
            chk("t6_latency", lat, 2);
            chk("t6_diff", diff1, dtab[idx]);
            chk("t6_bout", bout1, btab[idx]);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_subtractor
